// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory: count byte, then big-endian words written from address 0.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] words_loaded,
  output logic              cpu_hold
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_COUNT = 3'd1;
  localparam logic [2:0] S_BYTES = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHECK = 3'd4;
`endif
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [ADDR_W-1:0] words_q, words_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif
  logic              xfer;

  assign xfer = in_valid && in_ready;

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    count_d    = count_q;
    words_d    = words_q;
    addr_d     = addr_q;
    data_d     = data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_COUNT;
          byte_idx_d = 2'd0;
          words_d    = '0;
          addr_d     = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = 8'd0;
`endif
        end
      end
      S_COUNT: begin
        if (xfer) begin
          // Rejecting oversize counts here is what keeps every write below DEPTH.
          if (in_data == 8'd0 || int'(in_data) > DEPTH) begin
            state_d = S_ERR;
          end else begin
            count_d = ADDR_W'(in_data);
            state_d = S_BYTES;
          end
        end
      end
      S_BYTES: begin
        if (xfer) begin
          data_d     = {data_q[23:0], in_data};
          byte_idx_d = byte_idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = csum_q ^ in_data;
`endif
          if (byte_idx_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        addr_d     = addr_q + ADDR_W'(1);
        words_d    = words_q + ADDR_W'(1);
        byte_idx_d = 2'd0;
        if (words_q + ADDR_W'(1) == count_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_BYTES;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (xfer) state_d = (in_data == csum_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      byte_idx_q <= 2'd0;
      count_q    <= '0;
      words_q    <= '0;
      addr_q     <= '0;
      data_q     <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      count_q    <= count_d;
      words_q    <= words_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign in_ready = (state_q == S_COUNT) || (state_q == S_BYTES) || (state_q == S_CHECK);
`else
  assign in_ready = (state_q == S_COUNT) || (state_q == S_BYTES);
`endif
  assign mem_addr     = addr_q;
  assign mem_data     = data_q;
  assign mem_we       = (state_q == S_WRITE);
  assign busy         = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
  assign done         = (state_q == S_DONE);
  assign error        = (state_q == S_ERR);
  assign words_loaded = words_q;
  // start in DONE must re-hold the pipeline in the same cycle, not one later.
  assign cpu_hold     = (state_q != S_DONE) || start;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued as bytes are driven, checked on each mem_we.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        rst, start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, mem_we, busy, done, error, cpu_hold;
  logic [7:0]  mem_addr, words_loaded;
  logic [31:0] mem_data;

  imem_loader #(.ADDR_W(8), .DEPTH(64)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .busy(busy), .done(done), .error(error), .words_loaded(words_loaded), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          wr_count = 0;
  logic [39:0] exp_q[$];
  logic [39:0] mon_exp;
  logic [31:0] words[4];

  localparam logic [53:0] RST_VEC = 54'h1;
  logic [53:0] out_vec;
  assign out_vec = {in_ready, mem_addr, mem_data, mem_we, busy, done, error, words_loaded, cpu_hold};

  always @(negedge clk) begin
    if (mem_we) begin
      wr_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%h data=%h (no write expected)", mem_addr, mem_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({mem_addr, mem_data} !== mon_exp) begin
          errors++;
          $display("FAIL write_data got addr=%h data=%h expected addr=%h data=%h",
                   mem_addr, mem_data, mon_exp[39:32], mon_exp[31:0]);
        end
      end
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL write_in_ready got %b expected 0", in_ready);
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout byte=%h in_ready got 0 expected 1", b);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic load_words(input int nw, input bit gaps, input bit busy_start, input logic [7:0] csum_flip);
    logic [7:0] cs = 8'd0;
    logic [7:0] bt;
    int         wr0 = wr_count;
    bit         ok = (csum_flip == 8'd0);
    pulse_start();
    send_byte(8'(nw));
    for (int i = 0; i < nw; i++) begin
      exp_q.push_back({8'(i), words[i]});
      for (int b = 0; b < 4; b++) begin
        bt = words[i][31-8*b -: 8];
        cs ^= bt;
        if (gaps) @(negedge clk);
        send_byte(bt);
        if (busy_start && i == 0 && b == 1) pulse_start();
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(cs ^ csum_flip);
`else
    ok = 1'b1;
    @(negedge clk);
`endif
    checks++;
    if ({done, error} !== {ok, !ok}) begin
      errors++;
      $display("FAIL load_end_status done,error got %b%b expected %b%b", done, error, ok, !ok);
    end
    checks++;
    if (cpu_hold !== !ok) begin
      errors++;
      $display("FAIL load_cpu_hold got %b expected %b", cpu_hold, !ok);
    end
    checks++;
    if (words_loaded !== 8'(nw)) begin
      errors++;
      $display("FAIL load_words_loaded got %0d expected %0d", words_loaded, nw);
    end
    checks++;
    if (wr_count - wr0 != nw) begin
      errors++;
      $display("FAIL load_write_count got %0d expected %0d", wr_count - wr0, nw);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if (out_vec !== RST_VEC) begin
      errors++;
      $display("FAIL reset_values got %h expected %h", out_vec, RST_VEC);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_vec !== RST_VEC) begin
      errors++;
      $display("FAIL idle_values got %h expected %h", out_vec, RST_VEC);
    end
  endtask

  task automatic test_basic();
    words[0] = 32'h20010005; words[1] = 32'h00221820;
    load_words(2, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_valid_gaps();
    words[0] = 32'h20010005; words[1] = 32'h00221820;
    load_words(2, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic test_bad_count();
    int wr0 = wr_count;
    pulse_start();
    checks++;
    if ({done, error, busy} !== 3'b001) begin
      errors++;
      $display("FAIL start_clears done,error,busy got %b expected 001", {done, error, busy});
    end
    send_byte(8'h00);
    checks++;
    if ({error, done, cpu_hold, in_ready} !== 4'b1010) begin
      errors++;
      $display("FAIL count_zero error,done,hold,rdy got %b expected 1010", {error, done, cpu_hold, in_ready});
    end
    pulse_start();
    send_byte(8'h41);
    checks++;
    if ({error, done} !== 2'b10) begin
      errors++;
      $display("FAIL count_65 error,done got %b expected 10", {error, done});
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wr_count != wr0) begin
      errors++;
      $display("FAIL bad_count_writes got %0d expected 0", wr_count - wr0);
    end
    words[0] = 32'hCAFEF00D;
    load_words(1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_reset_mid_word();
    int wr0 = wr_count;
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h20);
    send_byte(8'h01);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (out_vec !== RST_VEC) begin
      errors++;
      $display("FAIL mid_reset_values got %h expected %h", out_vec, RST_VEC);
    end
    checks++;
    if (wr_count != wr0) begin
      errors++;
      $display("FAIL mid_reset_writes got %0d expected 0", wr_count - wr0);
    end
    words[0] = 32'h8C220004;
    load_words(1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_start_while_busy();
    words[0] = 32'hA1B2C3D4; words[1] = 32'h01020304; words[2] = 32'hFFEE0011;
    load_words(3, 1'b0, 1'b1, 8'h00);
    start = 1'b1;
    #1;
    checks++;
    if (cpu_hold !== 1'b1) begin
      errors++;
      $display("FAIL done_start_hold got %b expected 1", cpu_hold);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({words_loaded, busy, done} !== {8'h00, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL done_restart words,busy,done got %h,%b,%b expected 00,1,0", words_loaded, busy, done);
    end
    words[0] = 32'h13579BDF;
    load_words(1, 1'b0, 1'b0, 8'h00);
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    words[0] = 32'h12345678;
    load_words(1, 1'b0, 1'b0, 8'h00);
    load_words(1, 1'b0, 1'b0, 8'h01);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_valid_gaps();
    test_bad_count();
    test_reset_mid_word();
    test_start_while_busy();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_writes got %0d left expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer-side front end for the instruction memory. It takes a byte stream and writes assembled 32-bit instruction words into the memory write port, starting at address 0.
- It holds the pipeline in reset-hold until a complete program has been written.
- It replaces file-based instruction initialisation. It sits between an external byte source (bench or UART receiver) and the instruction memory's dataIn/address/writeEnable inputs.

Parameters:
- ADDR_W, 8, width of the memory word address; matches the 8-bit PC.
- DEPTH, 64, maximum number of words accepted; legal word count is 1..DEPTH.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte this cycle; a transfer happens when in_valid && in_ready.
- mem_addr  output  ADDR_W  word address for the write port.
- mem_data  output  32  assembled instruction word.
- mem_we  output  1  one-cycle write strobe.
- busy  output  1  high in every state except IDLE, DONE and ERR.
- done  output  1  load completed successfully; held high until start or rst.
- error  output  1  load aborted; held high until start or rst.
- words_loaded  output  ADDR_W  count of words written in the current load.
- cpu_hold  output  1  high except in DONE; drives pipeline reset/stall.

Behaviour:
- Reset values: in_ready=0, mem_addr=0, mem_data=0, mem_we=0, busy=0, done=0, error=0, words_loaded=0, cpu_hold=1, state=IDLE, byte index=0.
- States: IDLE, COUNT, BYTES, WRITE, (CHECK), DONE, ERR.
- IDLE: start moves to COUNT. It also clears done, error, words_loaded, mem_addr and the byte index.
- COUNT: in_ready=1. The accepted byte is the word count N.
  - N==0 or N>DEPTH goes to ERR.
  - Otherwise latch N and go to BYTES.
- BYTES: in_ready=1. Bytes are big-endian: the first byte goes to mem_data[31:24] and the fourth to mem_data[7:0].
  - The 2-bit byte index increments only on a transfer.
  - After the 4th transfer, go to WRITE.
- WRITE: in_ready=0, mem_we=1 for exactly one cycle, with mem_addr and mem_data stable.
  - Next cycle: mem_addr+1, words_loaded+1, byte index=0.
  - If words_loaded+1==N, go to DONE (or CHECK with the feature); otherwise return to BYTES.
- Latency: the mem_we cycle is the cycle immediately after the 4th byte transfer. done rises the cycle after the last WRITE.
- DONE: done=1, cpu_hold=0, in_ready=0. start begins a new load and re-asserts cpu_hold that same cycle.
- ERR: error=1, cpu_hold=1, in_ready=0, no writes. start restarts the load.
- start in COUNT, BYTES, WRITE or CHECK is ignored.
- in_valid while in_ready=0: the byte is not consumed. The source must hold it.
- mem_addr never exceeds DEPTH-1 for any write. The count check guarantees this; no wrap-around write can occur.
- rst mid-load: next cycle all outputs are at reset values and the partial word is discarded. Memory contents already written are not cleared.
- rst takes priority over start when both are high.

Optional Feature:
- IMEM_LOADER_CHECKSUM_EN defined:
  - After the last WRITE, go to CHECK with in_ready=1.
  - The accepted byte is compared with the XOR of all data bytes (the count byte excluded).
  - Match goes to DONE; mismatch goes to ERR. Words already written remain in memory.
- Undefined: no CHECK state; the last WRITE goes directly to DONE. No extra byte is consumed.

Test Plan:
- Basic load: rst, start, then stream 02, 20,01,00,05, 00,22,18,20 with in_valid continuous.
  - Required: mem_we pulses twice, addr0=0x20010005, addr1=0x00221820.
  - Then done=1, cpu_hold=0, words_loaded=2, error=0.
- Valid gaps: same stream with in_valid low every other cycle.
  - Required: identical writes, no duplicated or skipped byte, and in_ready=0 during each WRITE cycle.
- Bad count: stream 00, then separately 41 (65 > DEPTH).
  - Required: error=1, done=0, no mem_we. A following start with a valid stream recovers to done=1.
- Reset mid-word: start, 01, 20,01, then rst for one cycle.
  - Required: outputs at reset values, no mem_we.
  - A new load 01, 8C,22,00,04 writes addr0=0x8C220004.
- Start while busy: a start pulse during BYTES is ignored and the load completes normally.
  - start in DONE: cpu_hold=1 the same cycle and words_loaded=0.
- With IMEM_LOADER_CHECKSUM_EN: stream 01, 12,34,56,78 then 08 gives done=1.
  - Checksum byte 09 instead gives error=1, with addr0=0x12345678 already written.
